// File: rtl/generador_i2c.sv
// I2C master: register write / combined-format read with configurable address and data widths.
// Every bit slot is 2*CLK_DIV clocks: SCL low for the first half, high for the second.
// SDA is only changed at the middle of the low half, and iSDA is sampled at the middle of the high half.
module generador_i2c #(
    parameter int unsigned CLK_DIV    = 125,
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned DATA_BYTES = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    iStart,
    input  logic                    iRNW,
    input  logic [6:0]              iDevID,
    input  logic [8*ADDR_BYTES-1:0] iRegAddr,
    input  logic [8*DATA_BYTES-1:0] iWData,
    input  logic                    iSDA,
    output logic                    oSDA,
    output logic                    SCL,
    output logic [8*DATA_BYTES-1:0] oRData,
    output logic                    oBusy,
    output logic                    oDone,
    output logic                    oNack
);

    localparam int unsigned AW     = 8 * ADDR_BYTES;
    localparam int unsigned DW     = 8 * DATA_BYTES;
    localparam int unsigned SLOT   = 2 * CLK_DIV;
    localparam int unsigned CW     = $clog2(SLOT);
    localparam int unsigned MID_LO = CLK_DIV / 2;
    localparam int unsigned MID_HI = CLK_DIV + CLK_DIV / 2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_DEV    = 4'd2;
    localparam logic [3:0] S_ACK    = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_WDATA  = 4'd5;
    localparam logic [3:0] S_RSTART = 4'd6;
    localparam logic [3:0] S_DEVR   = 4'd7;
    localparam logic [3:0] S_RDATA  = 4'd8;
    localparam logic [3:0] S_MACK   = 4'd9;
    localparam logic [3:0] S_STOP   = 4'd10;

    // FSM registers
    logic [3:0]    state, state_n;
    logic [3:0]    ret_state, ret_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic [7:0]    tx, tx_n;
    logic          scl_n, sda_n;

    // Transaction context
    logic          rnw;
    logic [6:0]    dev;
    logic [AW-1:0] addr_sh;
    logic [DW-1:0] wdata_sh;
    logic [DW-1:0] rx_sh;
    logic          ack_bit;

    // Datapath strobes from the next-state logic
    logic latch_c, addr_pop_c, wdata_pop_c, rx_shift_c;
    logic ack_sample_c, nack_set_c, done_c, rdata_upd_c;

    logic slot_end;
    logic at_mid_hi;

    assign slot_end  = (cnt == CW'(SLOT - 1));
    assign at_mid_hi = (cnt == CW'(MID_HI));

    // State and bus-line registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            tx        <= '0;
            SCL       <= 1'b1;
            oSDA      <= 1'b1;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            byte_idx  <= byte_n;
            tx        <= tx_n;
            SCL       <= scl_n;
            oSDA      <= sda_n;
        end
    end

    // Next-state, divider, bus-line and strobe logic
    always_comb begin
        state_n      = state;
        ret_n        = ret_state;
        cnt_n        = cnt;
        bit_n        = bit_idx;
        byte_n       = byte_idx;
        tx_n         = tx;
        scl_n        = SCL;
        sda_n        = oSDA;
        latch_c      = 1'b0;
        addr_pop_c   = 1'b0;
        wdata_pop_c  = 1'b0;
        rx_shift_c   = 1'b0;
        ack_sample_c = 1'b0;
        nack_set_c   = 1'b0;
        done_c       = 1'b0;
        rdata_upd_c  = 1'b0;

        // Common slot timing: divider wraps every slot, SCL high in the second half
        if (state != S_IDLE && state != S_START) begin
            cnt_n = slot_end ? '0 : cnt + CW'(1);
            scl_n = (cnt_n >= CW'(CLK_DIV));
        end

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                scl_n = 1'b1;
                sda_n = 1'b1;
                if (iStart) begin
                    latch_c = 1'b1;
                    state_n = S_START;
                    sda_n   = 1'b0;
                end
            end

            S_START: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(CLK_DIV - 1)) begin
                    state_n = S_DEV;
                    cnt_n   = '0;
                    scl_n   = 1'b0;
                    tx_n    = {dev, 1'b0};
                    bit_n   = 3'd7;
                end
            end

            S_DEV, S_ADDR, S_WDATA, S_DEVR: begin
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = tx[7];
                end
                if (slot_end) begin
                    if (bit_idx == 3'd0) begin
                        state_n = S_ACK;
                        ret_n   = state;
                    end else begin
                        bit_n = bit_idx - 3'd1;
                        tx_n  = {tx[6:0], 1'b0};
                    end
                end
            end

            S_ACK: begin
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = 1'b1;
                end
                if (at_mid_hi) begin
                    ack_sample_c = 1'b1;
                end
                if (slot_end) begin
                    bit_n = 3'd7;
                    if (ack_bit) begin
                        nack_set_c = 1'b1;
                        state_n    = S_STOP;
                    end else begin
                        case (ret_state)
                            S_DEV: begin
                                state_n    = S_ADDR;
                                byte_n     = 2'd0;
                                tx_n       = addr_sh[AW-1 -: 8];
                                addr_pop_c = 1'b1;
                            end
                            S_ADDR: begin
                                if (byte_idx == 2'(ADDR_BYTES - 1)) begin
                                    if (rnw) begin
                                        state_n = S_RSTART;
                                    end else begin
                                        state_n     = S_WDATA;
                                        byte_n      = 2'd0;
                                        tx_n        = wdata_sh[DW-1 -: 8];
                                        wdata_pop_c = 1'b1;
                                    end
                                end else begin
                                    byte_n     = byte_idx + 2'd1;
                                    state_n    = S_ADDR;
                                    tx_n       = addr_sh[AW-1 -: 8];
                                    addr_pop_c = 1'b1;
                                end
                            end
                            S_WDATA: begin
                                if (byte_idx == 2'(DATA_BYTES - 1)) begin
                                    state_n = S_STOP;
                                end else begin
                                    byte_n      = byte_idx + 2'd1;
                                    state_n     = S_WDATA;
                                    tx_n        = wdata_sh[DW-1 -: 8];
                                    wdata_pop_c = 1'b1;
                                end
                            end
                            S_DEVR: begin
                                state_n = S_RDATA;
                                byte_n  = 2'd0;
                            end
                            default: state_n = S_STOP;
                        endcase
                    end
                end
            end

            S_RSTART: begin
                // Release SDA while SCL is low, then pull it low with SCL high
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = 1'b1;
                end
                if (cnt_n == CW'(MID_HI)) begin
                    sda_n = 1'b0;
                end
                if (slot_end) begin
                    state_n = S_DEVR;
                    tx_n    = {dev, 1'b1};
                    bit_n   = 3'd7;
                end
            end

            S_RDATA: begin
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = 1'b1;
                end
                if (at_mid_hi) begin
                    rx_shift_c = 1'b1;
                end
                if (slot_end) begin
                    if (bit_idx == 3'd0) begin
                        state_n = S_MACK;
                    end else begin
                        bit_n = bit_idx - 3'd1;
                    end
                end
            end

            S_MACK: begin
                // ACK every byte except the last, which is NACKed to end the read
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = (byte_idx == 2'(DATA_BYTES - 1));
                end
                if (slot_end) begin
                    if (byte_idx == 2'(DATA_BYTES - 1)) begin
                        state_n = S_STOP;
                    end else begin
                        state_n = S_RDATA;
                        byte_n  = byte_idx + 2'd1;
                        bit_n   = 3'd7;
                    end
                end
            end

            S_STOP: begin
                if (cnt_n == CW'(MID_LO)) begin
                    sda_n = 1'b0;
                end
                if (cnt_n == CW'(MID_HI)) begin
                    sda_n = 1'b1;
                end
                if (slot_end) begin
                    state_n     = S_IDLE;
                    scl_n       = 1'b1;
                    sda_n       = 1'b1;
                    done_c      = 1'b1;
                    rdata_upd_c = rnw & ~oNack;
                end
            end

            default: begin
                state_n = S_IDLE;
                scl_n   = 1'b1;
                sda_n   = 1'b1;
                cnt_n   = '0;
            end
        endcase
    end

    // Transaction context, receive shifter and status outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rnw      <= 1'b0;
            dev      <= '0;
            addr_sh  <= '0;
            wdata_sh <= '0;
            rx_sh    <= '0;
            ack_bit  <= 1'b0;
            oRData   <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oNack    <= 1'b0;
        end else begin
            if (latch_c) begin
                rnw      <= iRNW;
                dev      <= iDevID;
                addr_sh  <= iRegAddr;
                wdata_sh <= iWData;
                oNack    <= 1'b0;
            end
            if (addr_pop_c) begin
                addr_sh <= addr_sh << 8;
            end
            if (wdata_pop_c) begin
                wdata_sh <= wdata_sh << 8;
            end
            if (ack_sample_c) begin
                ack_bit <= iSDA;
            end
            if (nack_set_c) begin
                oNack <= 1'b1;
            end
            if (rx_shift_c) begin
                rx_sh <= {rx_sh[DW-2:0], iSDA};
            end
            if (rdata_upd_c) begin
                oRData <= rx_sh;
            end
            oDone <= done_c;
            oBusy <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_generador_i2c.sv
// Randomized scoreboard bench for generador_i2c with a bit-level I2C slave model on the bus.
module tb_generador_i2c;

    localparam int CD = 8;
    localparam int A  = 2;
    localparam int D  = 2;
    localparam int AW = 8 * A;
    localparam int DW = 8 * D;

    typedef struct {
        longint      t0;
        int          lat;
        int          nbytes;
        logic [63:0] bytes;
        bit          nack;
        logic [DW-1:0] rdata;
        int          starts;
        int          nmack;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iStart = 1'b0;
    logic          iRNW = 1'b0;
    logic [6:0]    iDevID = '0;
    logic [AW-1:0] iRegAddr = '0;
    logic [DW-1:0] iWData = '0;
    wire           iSDA;
    logic          oSDA, SCL, oBusy, oDone, oNack;
    logic [DW-1:0] oRData;

    logic          sl_sda = 1'b1;
    assign iSDA = oSDA & sl_sda;

    generador_i2c #(.CLK_DIV(CD), .ADDR_BYTES(A), .DATA_BYTES(D)) dut (
        .CLK(clk), .Reset(rst), .iStart(iStart), .iRNW(iRNW), .iDevID(iDevID),
        .iRegAddr(iRegAddr), .iWData(iWData), .iSDA(iSDA), .oSDA(oSDA), .SCL(SCL),
        .oRData(oRData), .oBusy(oBusy), .oDone(oDone), .oNack(oNack)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;
    int done_seen = 0;
    exp_t sb[$];
    logic [DW-1:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Slave model: decodes bytes from SCL/SDA edges, ACKs (or NACKs one planned byte), serves read data
    int          pos = 0;
    logic [7:0]  rx_byte = '0;
    bit          first_byte = 0, rd_pending = 0, tx_mode = 0;
    logic [DW-1:0] tx_word = '0;
    logic [7:0]  byte_log[$];
    bit          mack_log[$];
    int          start_cnt = 0, stop_cnt = 0, nack_at = -1;
    logic [DW-1:0] slave_rdata = '0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        logic line;
        line = oSDA & sl_sda;
        if (rst) begin
            pos = 0; sl_sda = 1'b1; tx_mode = 0; rd_pending = 0; first_byte = 0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (prev_scl && SCL && prev_sda && !line) begin
                start_cnt++; pos = 0; first_byte = 1; tx_mode = 0;
            end else if (prev_scl && SCL && !prev_sda && line) begin
                stop_cnt++;
            end else if (!prev_scl && SCL) begin
                if (pos < 8) rx_byte = {rx_byte[6:0], line};
                else if (pos == 8 && tx_mode) mack_log.push_back(line);
                pos++;
            end else if (prev_scl && !SCL) begin
                if (pos == 8) begin
                    if (!tx_mode) begin
                        byte_log.push_back(rx_byte);
                        if (byte_log.size() - 1 == nack_at) sl_sda = 1'b1;
                        else begin
                            sl_sda = 1'b0;
                            if (first_byte && rx_byte[0]) rd_pending = 1;
                        end
                        first_byte = 0;
                    end else begin
                        sl_sda = 1'b1;
                    end
                end else if (pos == 9) begin
                    pos = 0;
                    sl_sda = 1'b1;
                    if (rd_pending) begin
                        rd_pending = 0; tx_mode = 1; tx_word = slave_rdata;
                    end else if (tx_mode && mack_log.size() > 0 && mack_log[mack_log.size()-1]) begin
                        tx_mode = 0;
                    end
                    if (tx_mode) begin sl_sda = tx_word[DW-1]; tx_word = tx_word << 1; end
                end else if (tx_mode) begin
                    sl_sda = tx_word[DW-1]; tx_word = tx_word << 1;
                end
            end
            prev_scl = SCL;
            prev_sda = oSDA & sl_sda;
        end
    end

    // Reference model: the bytes the master must put on the bus and the resulting timing/status
    function automatic exp_t build_exp(input bit rnw, input logic [6:0] dev, input logic [AW-1:0] addr,
                                       input logic [DW-1:0] wd, input int nk, input logic [DW-1:0] sd,
                                       input logic [DW-1:0] prev);
        exp_t e;
        logic [7:0] sent[$];
        int n, m;
        bit nacked;
        sent.push_back({dev, 1'b0});
        for (int i = 0; i < A; i++) sent.push_back(addr[8*(A-1-i) +: 8]);
        if (!rnw) for (int i = 0; i < D; i++) sent.push_back(wd[8*(D-1-i) +: 8]);
        else sent.push_back({dev, 1'b1});
        n = sent.size();
        nacked = (nk >= 0 && nk < n);
        m = nacked ? nk + 1 : n;
        e.bytes = '0;
        for (int i = 0; i < m; i++) e.bytes[8*i +: 8] = sent[i];
        e.nbytes = m;
        e.nack = nacked;
        if (!rnw || m <= 1 + A) e.lat = CD * (1 + 18 * m + 2);
        else if (nacked)        e.lat = CD * (1 + 18 * (1 + A) + 2 + 18 + 2);
        else                    e.lat = CD * (1 + 18 * (1 + A) + 2 + 18 * (1 + D) + 2);
        e.starts = (rnw && m == n) ? 2 : 1;
        e.nmack  = (rnw && !nacked) ? D : 0;
        e.rdata  = (rnw && !nacked) ? sd : prev;
        e.t0 = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (!rst && oDone) begin
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                logic [63:0] got_b, got_m, exp_m;
                e = sb.pop_front();
                got_b = '0; got_m = '0; exp_m = '0;
                for (int i = 0; i < byte_log.size() && i < 8; i++) got_b[8*i +: 8] = byte_log[i];
                for (int i = 0; i < mack_log.size() && i < 64; i++) got_m[i] = mack_log[i];
                for (int i = 0; i < e.nmack; i++) exp_m[i] = (i == e.nmack - 1);
                chk("done_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("byte_count", 64'(byte_log.size()), 64'(e.nbytes));
                chk("sda_bytes", got_b, e.bytes);
                chk("nack", 64'(oNack), 64'(e.nack));
                chk("rdata", 64'(oRData), 64'(e.rdata));
                chk("start_count", 64'(start_cnt), 64'(e.starts));
                chk("stop_count", 64'(stop_cnt), 64'd1);
                chk("mack_count", 64'(mack_log.size()), 64'(e.nmack));
                chk("mack_bits", got_m, exp_m);
                chk("busy_low_at_done", 64'(oBusy), 64'd0);
            end
        end
    end

    task automatic start_txn(input bit rnw, input logic [6:0] dev, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input int nk, input logic [DW-1:0] sd);
        exp_t e;
        @(negedge clk);
        byte_log.delete(); mack_log.delete();
        start_cnt = 0; stop_cnt = 0; nack_at = nk; slave_rdata = sd;
        iRNW = rnw; iDevID = dev; iRegAddr = addr; iWData = wd; iStart = 1'b1;
        e = build_exp(rnw, dev, addr, wd, nk, sd, exp_rdata);
        e.t0 = cyc + 1;
        sb.push_back(e);
        exp_rdata = e.rdata;
        @(negedge clk);
        iStart = 1'b0;
        chk("busy_after_start", 64'(oBusy), 64'd1);
        chk("nack_cleared_at_start", 64'(oNack), 64'd0);
    endtask

    // Wait for completion while poking iStart and scrambling inputs; both must be ignored
    task automatic run_busy();
        for (int i = 0; i < 4000; i++) begin
            if (!oBusy) break;
            if ($urandom_range(0, 15) == 0) begin
                iStart = 1'b1;
                iRNW = 1'($urandom_range(0, 1));
                iDevID = 7'($urandom);
                iRegAddr = AW'($urandom);
                iWData = DW'($urandom);
            end else begin
                iStart = 1'b0;
            end
            @(negedge clk);
        end
        iStart = 1'b0;
        chk("txn_timeout", 64'(oBusy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_txn(input bit rnw, input logic [6:0] dev, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int nk, input logic [DW-1:0] sd);
        start_txn(rnw, dev, addr, wd, nk, sd);
        run_busy();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, d0;
        logic s_scl, s_sda;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_scl", 64'(SCL), 64'd1);
        chk("reset_sda", 64'(oSDA), 64'd1);
        chk("reset_busy", 64'(oBusy), 64'd0);
        chk("reset_done", 64'(oDone), 64'd0);
        chk("reset_nack", 64'(oNack), 64'd0);
        chk("reset_rdata", 64'(oRData), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: write, read, NACK on device byte, read NACKed on last address byte
        do_txn(1'b0, 7'h0A, 16'h0051, 16'h0001, -1, 16'h0000);
        do_txn(1'b1, 7'h0A, 16'h0051, 16'h0000, -1, 16'hBEEF);
        do_txn(1'b0, 7'h0A, 16'h0051, 16'h1234, 0, 16'h0000);
        do_txn(1'b1, 7'h33, 16'hA5C3, 16'h0000, 2, 16'h1234);

        // Abort: NACK on last address byte, reset after the NACK is flagged but before STOP ends
        start_txn(1'b0, 7'h21, 16'hC0DE, 16'h5A5A, 2, 16'h0000);
        repeat (CD * (1 + 18 * 3 + 2) - CD - 1) @(negedge clk);
        chk("nack_before_abort", 64'(oNack), 64'd1);
        chk("busy_before_abort", 64'(oBusy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_scl", 64'(SCL), 64'd1);
        chk("abort_sda", 64'(oSDA), 64'd1);
        chk("abort_busy", 64'(oBusy), 64'd0);
        chk("abort_done", 64'(oDone), 64'd0);
        chk("abort_nack", 64'(oNack), 64'd0);
        chk("abort_rdata", 64'(oRData), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_rdata = '0;
        d0 = done_seen;
        repeat (1500) @(negedge clk);
        chk("no_done_after_abort", 64'(done_seen - d0), 64'd0);

        // iStart together with Reset must not start anything
        @(negedge clk);
        rst = 1'b1; iStart = 1'b1; iRNW = 1'b0; iDevID = 7'h11;
        @(negedge clk);
        rst = 1'b0; iStart = 1'b0;
        bad = 0;
        s_scl = SCL; s_sda = oSDA;
        for (int i = 0; i < 60; i++) begin
            if (oBusy !== 1'b0 || SCL !== 1'b1 || oSDA !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("start_with_reset_ignored", 64'(bad), 64'd0);
        chk("bus_idle_after_reset", 64'({s_scl, s_sda}), 64'd3);

        // A new request is accepted after reset
        do_txn(1'b1, 7'h0A, 16'h0051, 16'h0000, -1, 16'h0F0F);

        // Randomized transactions
        for (int k = 0; k < 20; k++) begin
            bit r;
            int n, nk;
            r = 1'($urandom_range(0, 1));
            n = r ? 2 + A : 1 + A + D;
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            do_txn(r, 7'($urandom), AW'($urandom), DW'($urandom), nk, DW'($urandom));
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
